// File: rtl/complex_acc_if.sv
// Handshake bus between the complex multiplier and the frame accumulator:
// product samples flow in, accumulated frame results flow out.
interface complex_acc_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH+4
);
    logic                    in_val;
    logic                    in_ready;
    logic [2*DATA_WIDTH-1:0] in_re;
    logic [2*DATA_WIDTH-1:0] in_im;
    logic                    out_val;
    logic                    out_ready;
    logic [ACC_WIDTH-1:0]    out_re;
    logic [ACC_WIDTH-1:0]    out_im;
    logic                    out_ovf;

    modport master (
        output in_val, in_re, in_im, out_ready,
        input  in_ready, out_val, out_re, out_im, out_ovf
    );

    modport slave (
        input  in_val, in_re, in_im, out_ready,
        output in_ready, out_val, out_re, out_im, out_ovf
    );
endinterface

// File: rtl/complex_acc.sv
// Sums ACC_LEN complex products per frame and presents each frame result,
// with a sticky signed-overflow flag, until the consumer takes it.
module complex_acc #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_LEN    = 4,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH+4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             sw_rst,
    complex_acc_if.slave     bus
);
    localparam int CNT_W = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
    localparam logic [CNT_W-1:0]     CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(ACC_LEN-1);
    localparam logic [ACC_WIDTH-1:0] ACC_ZERO = {ACC_WIDTH{1'b0}};

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [ACC_WIDTH-1:0] r_acc_re;
    logic [ACC_WIDTH-1:0] r_acc_im;
    logic                 r_sticky;
    logic [ACC_WIDTH-1:0] r_out_re;
    logic [ACC_WIDTH-1:0] r_out_im;
    logic                 r_out_ovf;

    logic [ACC_WIDTH-1:0] w_ext_re;
    logic [ACC_WIDTH-1:0] w_ext_im;
    logic [ACC_WIDTH-1:0] w_sum_re;
    logic [ACC_WIDTH-1:0] w_sum_im;
    logic                 w_add_ovf;
    logic                 w_accept;
    logic                 w_last;

    // Two's-complement add overflow: equal operand signs, different result sign.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

    assign w_ext_re  = ACC_WIDTH'($signed(bus.in_re));
    assign w_ext_im  = ACC_WIDTH'($signed(bus.in_im));
    assign w_sum_re  = r_acc_re + w_ext_re;
    assign w_sum_im  = r_acc_im + w_ext_im;
    assign w_add_ovf = add_ovf(r_acc_re[ACC_WIDTH-1], w_ext_re[ACC_WIDTH-1], w_sum_re[ACC_WIDTH-1])
                     | add_ovf(r_acc_im[ACC_WIDTH-1], w_ext_im[ACC_WIDTH-1], w_sum_im[ACC_WIDTH-1]);

    assign w_accept = (r_state == ST_ACCUM) && bus.in_val;
    assign w_last   = w_accept && (r_cnt == CNT_LAST);

    // Ready/valid come only from the state register, never from out_ready.
    assign bus.in_ready = (r_state == ST_ACCUM);
    assign bus.out_val  = (r_state == ST_HOLD);
    assign bus.out_re   = r_out_re;
    assign bus.out_im   = r_out_im;
    assign bus.out_ovf  = r_out_ovf;

    // Next-state decode: the last sample of a frame moves to HOLD, a taken result returns to ACCUM.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_ACCUM: begin
                if (w_last) w_state_nxt = ST_HOLD;
                else        w_state_nxt = ST_ACCUM;
            end
            ST_HOLD: begin
                if (bus.out_ready) w_state_nxt = ST_ACCUM;
                else               w_state_nxt = ST_HOLD;
            end
            default: w_state_nxt = ST_ACCUM;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_ACCUM;
        end else if (sw_rst) begin
            r_state <= ST_ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Accumulators, sample counter, sticky flag and the held frame result.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt     <= CNT_ZERO;
            r_acc_re  <= ACC_ZERO;
            r_acc_im  <= ACC_ZERO;
            r_sticky  <= 1'b0;
            r_out_re  <= ACC_ZERO;
            r_out_im  <= ACC_ZERO;
            r_out_ovf <= 1'b0;
        end else if (sw_rst) begin
            r_cnt     <= CNT_ZERO;
            r_acc_re  <= ACC_ZERO;
            r_acc_im  <= ACC_ZERO;
            r_sticky  <= 1'b0;
            r_out_re  <= ACC_ZERO;
            r_out_im  <= ACC_ZERO;
            r_out_ovf <= 1'b0;
        end else if (w_last) begin
            r_out_re  <= w_sum_re;
            r_out_im  <= w_sum_im;
            r_out_ovf <= r_sticky | w_add_ovf;
            r_cnt     <= CNT_ZERO;
            r_acc_re  <= ACC_ZERO;
            r_acc_im  <= ACC_ZERO;
            r_sticky  <= 1'b0;
        end else if (w_accept) begin
            r_cnt     <= r_cnt + CNT_ONE;
            r_acc_re  <= w_sum_re;
            r_acc_im  <= w_sum_im;
            r_sticky  <= r_sticky | w_add_ovf;
        end else begin
            r_cnt     <= r_cnt;
            r_acc_re  <= r_acc_re;
            r_acc_im  <= r_acc_im;
            r_sticky  <= r_sticky;
        end
    end
endmodule

// File: tb/tb_complex_acc.sv
// Scoreboard bench for complex_acc: a default-width instance and a 17-bit
// accumulator instance for the wrap/overflow case.
module tb_complex_acc;
    localparam int DW = 8;
    localparam int AL = 4;

    logic clk    = 1'b0;
    logic rstn   = 1'b0;
    logic sw_rst = 1'b0;

    always #5 clk = ~clk;

    complex_acc_if #(.DATA_WIDTH(DW), .ACC_WIDTH(20)) bus   ();
    complex_acc_if #(.DATA_WIDTH(DW), .ACC_WIDTH(17)) bus17 ();

    complex_acc #(.DATA_WIDTH(DW), .ACC_LEN(AL), .ACC_WIDTH(20)) dut (
        .clk(clk), .rstn(rstn), .sw_rst(sw_rst), .bus(bus)
    );
    complex_acc #(.DATA_WIDTH(DW), .ACC_LEN(AL), .ACC_WIDTH(17)) dut17 (
        .clk(clk), .rstn(rstn), .sw_rst(sw_rst), .bus(bus17)
    );

    typedef struct {
        longint re;
        longint im;
        longint ovf;
    } res_t;

    res_t   sb0[$];
    res_t   sb1[$];
    res_t   cur[2];
    int     w_tab[2];
    longint m_re[2];
    longint m_im[2];
    int     m_cnt[2];
    longint m_stk[2];
    int     n_chk  = 0;
    int     n_fail = 0;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint wrapw(input longint t, input int w);
        longint full, half, r;
        full = 64'sd1 <<< w;
        half = 64'sd1 <<< (w-1);
        r = t % full;
        if (r < 0) r = r + full;
        if (r >= half) r = r - full;
        return r;
    endfunction

    function automatic longint out_of_range(input longint t, input int w);
        longint half;
        half = 64'sd1 <<< (w-1);
        return ((t >= half) || (t < -half)) ? 64'sd1 : 64'sd0;
    endfunction

    task automatic model_reset(input int d);
        m_re[d] = 0; m_im[d] = 0; m_cnt[d] = 0; m_stk[d] = 0;
        cur[d].re = 0; cur[d].im = 0; cur[d].ovf = 0;
    endtask

    function automatic bit model_push(input int d, input longint re, input longint im);
        longint tr, ti;
        res_t   r;
        tr = m_re[d] + re;
        ti = m_im[d] + im;
        if (out_of_range(tr, w_tab[d]) != 0 || out_of_range(ti, w_tab[d]) != 0) m_stk[d] = 1;
        m_re[d] = wrapw(tr, w_tab[d]);
        m_im[d] = wrapw(ti, w_tab[d]);
        m_cnt[d]++;
        if (m_cnt[d] == AL) begin
            r.re = m_re[d]; r.im = m_im[d]; r.ovf = m_stk[d];
            if (d == 0) sb0.push_back(r);
            else        sb1.push_back(r);
            m_re[d] = 0; m_im[d] = 0; m_cnt[d] = 0; m_stk[d] = 0;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic rdy(input int d);
        return (d == 0) ? bus.in_ready : bus17.in_ready;
    endfunction

    function automatic logic oval(input int d);
        return (d == 0) ? bus.out_val : bus17.out_val;
    endfunction

    task automatic drive(input int d, input logic v, input longint re, input longint im);
        if (d == 0) begin
            bus.in_val = v; bus.in_re = 16'(re); bus.in_im = 16'(im);
        end else begin
            bus17.in_val = v; bus17.in_re = 16'(re); bus17.in_im = 16'(im);
        end
    endtask

    // Offer one sample after 'gap' idle cycles; call and return just after a falling edge.
    task automatic send(input int d, input longint re, input longint im, input int gap);
        int budget;
        bit last;
        drive(d, 1'b0, 0, 0);
        repeat (gap) @(negedge clk);
        drive(d, 1'b1, re, im);
        budget = 0;
        while (rdy(d) !== 1'b1 && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 50) begin
            check_eq("in_ready_timeout", longint'(budget), 0);
            drive(d, 1'b0, 0, 0);
            return;
        end
        @(posedge clk);
        last = model_push(d, re, im);
        @(negedge clk);
        drive(d, 1'b0, 0, 0);
        if (last) begin
            check_eq("latency_out_val", longint'(oval(d)), 1);
            check_eq("latency_in_ready", longint'(rdy(d)), 0);
        end
    endtask

    task automatic mon_step(input int d, input logic v, input logic prev,
                            input longint re, input longint im, input logic ovf);
        if (v && !prev) begin
            if (d == 0) begin
                check_eq("sb0_has_frame", longint'(sb0.size()), 1);
                if (sb0.size() > 0) cur[0] = sb0.pop_front();
            end else begin
                check_eq("sb1_has_frame", longint'(sb1.size()), 1);
                if (sb1.size() > 0) cur[1] = sb1.pop_front();
            end
        end
        check_eq((d == 0) ? "out_re" : "out_re17", re, cur[d].re);
        check_eq((d == 0) ? "out_im" : "out_im17", im, cur[d].im);
        check_eq((d == 0) ? "out_ovf" : "out_ovf17", longint'(ovf), cur[d].ovf);
    endtask

    // Output monitor: pops a new expectation when a frame appears, checks held values every cycle.
    initial begin
        logic p0, p1;
        p0 = 1'b0; p1 = 1'b0;
        forever begin
            @(negedge clk);
            if (rstn) begin
                mon_step(0, bus.out_val, p0, longint'($signed(bus.out_re)),
                         longint'($signed(bus.out_im)), bus.out_ovf);
                mon_step(1, bus17.out_val, p1, longint'($signed(bus17.out_re)),
                         longint'($signed(bus17.out_im)), bus17.out_ovf);
            end
            p0 = bus.out_val;
            p1 = bus17.out_val;
        end
    end

    initial begin
        w_tab[0] = 20; w_tab[1] = 17;
        model_reset(0); model_reset(1);
        drive(0, 1'b0, 0, 0); drive(1, 1'b0, 0, 0);
        bus.out_ready = 1'b1; bus17.out_ready = 1'b1;

        // Reset values
        repeat (3) @(negedge clk);
        check_eq("rst_out_val", longint'(bus.out_val), 0);
        check_eq("rst_out_re", longint'(bus.out_re), 0);
        check_eq("rst_out_ovf", longint'(bus.out_ovf), 0);
        #2 rstn = 1'b1;
        @(negedge clk);
        check_eq("rst_in_ready", longint'(bus.in_ready), 1);

        // Back-to-back frame
        for (int i = 0; i < AL; i++) send(0, 100, -3, 0);
        @(negedge clk);
        check_eq("b2b_in_ready", longint'(bus.in_ready), 1);
        check_eq("b2b_out_val", longint'(bus.out_val), 0);

        // Gapped frame, -1 + j1 each
        for (int i = 0; i < AL; i++) send(0, -1, 1, 2);
        @(negedge clk);
        check_eq("gap_out_re_bits", longint'(bus.out_re), longint'(20'hFFFFC));

        // Consumer stall with in_val pending during HOLD
        for (int i = 0; i < AL-1; i++) send(0, 5, 6, 0);
        bus.out_ready = 1'b0;
        send(0, 5, 6, 0);
        drive(0, 1'b1, 77, 77);
        for (int i = 0; i < 5; i++) begin
            check_eq("hold_out_val", longint'(bus.out_val), 1);
            check_eq("hold_in_ready", longint'(bus.in_ready), 0);
            @(negedge clk);
        end
        drive(0, 1'b0, 0, 0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        check_eq("release_out_val", longint'(bus.out_val), 0);
        check_eq("release_in_ready", longint'(bus.in_ready), 1);
        for (int i = 0; i < AL; i++) send(0, 1, 2, 0);
        @(negedge clk);

        // 17-bit accumulator wrap and sticky overflow
        for (int i = 0; i < AL; i++) send(1, 32767, 0, 0);
        @(negedge clk);
        check_eq("wrap_out_re_bits", longint'(bus17.out_re), longint'(17'h1FFFC));
        for (int i = 0; i < AL; i++) send(1, 0, 0, 0);
        @(negedge clk);

        // Soft reset mid-frame
        for (int i = 0; i < 2; i++) send(0, 10, 0, 0);
        sw_rst = 1'b1;
        @(posedge clk);
        model_reset(0); model_reset(1);
        @(negedge clk);
        sw_rst = 1'b0;
        check_eq("srst_in_ready", longint'(bus.in_ready), 1);
        check_eq("srst_out_val", longint'(bus.out_val), 0);
        for (int i = 0; i < AL-1; i++) send(0, 1, 0, 0);
        bus.out_ready = 1'b0;
        send(0, 1, 0, 0);

        // Asynchronous reset while holding a result
        #2 rstn = 1'b0;
        #1;
        check_eq("arst_out_val", longint'(bus.out_val), 0);
        check_eq("arst_out_re", longint'(bus.out_re), 0);
        check_eq("arst_in_ready", longint'(bus.in_ready), 1);
        model_reset(0); model_reset(1);
        @(negedge clk);
        #2 rstn = 1'b1;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);

        check_eq("sb0_empty", longint'(sb0.size()), 0);
        check_eq("sb1_empty", longint'(sb1.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
